// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a {reg_addr, reg_val} table ROM after power-up.
// Each entry becomes one SCCB-style 3-byte write on the byte-level I2C master:
// START, DEV_ADDR, reg_addr, reg_val, STOP. The table can also hold delay
// entries (16'hFFF0) and an end marker (16'hFFFF). A command that hangs
// longer than TIMEOUT_CYCLES resets the master and ends the load with err.
//
// Master handshake: a command is offered while the FSM is in CMD. m_i2c_en is
// asserted only while the master reports m_ready=1, so the master's accept is
// the cycle where m_i2c_en && m_ready. The FSM then waits for m_ready to fall
// (accepted) and rise again (finished) before it offers the next command.
module i2c_cfg_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h42,
    parameter int         ROM_AW         = 8,
    parameter int         DELAY_CYCLES   = 1_000_000,
    parameter int         TIMEOUT_CYCLES = 20_000,
    parameter int         GAP_CYCLES     = 1_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        m_tx_data,
    output logic              m_start,
    output logic              m_stop,
    output logic              m_i2c_en,
    input  logic              m_ready,
    input  logic              m_tx_done,
    output logic              m_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROM_AW-1:0] entry_cnt
);

    // One wait counter serves GAP, DELAY and the CMD/ACC timeout; it is
    // cleared on entry to each of those phases, so the phases never overlap.
    localparam int CNT_MAX_A = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYCLES - 1);

    localparam logic [15:0] MARK_END   = 16'hFFFF;
    localparam logic [15:0] MARK_DELAY = 16'hFFF0;
    localparam logic [2:0]  STEP_LAST  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_CMD,
        S_ACC,
        S_CMPL,
        S_GAP,
        S_DELAY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_AW-1:0] entry_cnt_q, entry_cnt_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [7:0]        reg_val_q, reg_val_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [2:0]        step_q, step_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              issued_q, issued_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              m_rst_q, m_rst_d;
    // Byte-complete flag of the current command, kept for debug probes only.
    logic              tx_done_seen_q, tx_done_seen_d;
    logic              cmd_timeout;

    // Byte carried by each step of the 5-command transaction (0 for START/STOP).
    function automatic logic [7:0] step_byte(input logic [2:0] s,
                                             input logic [7:0] ra,
                                             input logic [7:0] rv);
        case (s)
            3'd1:    step_byte = DEV_ADDR;
            3'd2:    step_byte = ra;
            3'd3:    step_byte = rv;
            default: step_byte = 8'h00;
        endcase
    endfunction

    assign cmd_timeout = (cnt_q == TMO_LAST);

    // Command fields: en only in CMD and only while the master is ready.
    assign m_i2c_en  = (state_q == S_CMD) && m_ready;
    assign m_start   = (state_q == S_CMD) && (step_q == 3'd0);
    assign m_stop    = (state_q == S_CMD) && (step_q == STEP_LAST);
    assign m_tx_data = tx_data_q;
    assign rom_addr  = rom_addr_q;
    assign entry_cnt = entry_cnt_q;
    assign m_rst     = m_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // Next-state and datapath updates for the table walk.
    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        entry_cnt_d    = entry_cnt_q;
        reg_addr_d     = reg_addr_q;
        reg_val_d      = reg_val_q;
        tx_data_d      = tx_data_q;
        step_d         = step_q;
        cnt_d          = cnt_q;
        issued_d       = issued_q;
        busy_d         = busy_q;
        done_d         = done_q;
        err_d          = err_q;
        m_rst_d        = 1'b0;
        tx_done_seen_d = tx_done_seen_q | m_tx_done;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    rom_addr_d  = '0;
                    entry_cnt_d = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                cnt_d = '0;
                if (rom_data == MARK_END) begin
                    state_d = S_DONE;
                end else if (rom_data == MARK_DELAY) begin
                    state_d = S_DELAY;
                end else begin
                    reg_addr_d     = rom_data[15:8];
                    reg_val_d      = rom_data[7:0];
                    step_d         = 3'd0;
                    issued_d       = 1'b0;
                    tx_done_seen_d = 1'b0;
                    state_d        = S_CMD;
                end
            end
            S_CMD: begin
                cnt_d = cnt_q + 1'b1;
                if (cmd_timeout) begin
                    m_rst_d   = 1'b1;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    tx_data_d = 8'h00;
                    state_d   = S_IDLE;
                end else if (m_ready) begin
                    issued_d = 1'b1;
                end else if (issued_q) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                cnt_d = cnt_q + 1'b1;
                if (cmd_timeout) begin
                    m_rst_d   = 1'b1;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    tx_data_d = 8'h00;
                    state_d   = S_IDLE;
                end else if (m_ready) begin
                    // Load the next byte now so it is stable a cycle before en.
                    tx_data_d = step_byte(step_q + 3'd1, reg_addr_q, reg_val_q);
                    state_d   = S_CMPL;
                end
            end
            S_CMPL: begin
                cnt_d = '0;
                if (step_q < STEP_LAST) begin
                    step_d         = step_q + 3'd1;
                    issued_d       = 1'b0;
                    tx_done_seen_d = 1'b0;
                    state_d        = S_CMD;
                end else begin
                    entry_cnt_d = entry_cnt_q + 1'b1;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    if (rom_addr_q == {ROM_AW{1'b1}}) begin
                        state_d = S_DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DELAY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DLY_LAST) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset returns everything to idle zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rom_addr_q     <= '0;
            entry_cnt_q    <= '0;
            reg_addr_q     <= 8'h00;
            reg_val_q      <= 8'h00;
            tx_data_q      <= 8'h00;
            step_q         <= 3'd0;
            cnt_q          <= '0;
            issued_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            m_rst_q        <= 1'b0;
            tx_done_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            entry_cnt_q    <= entry_cnt_d;
            reg_addr_q     <= reg_addr_d;
            reg_val_q      <= reg_val_d;
            tx_data_q      <= tx_data_d;
            step_q         <= step_d;
            cnt_q          <= cnt_d;
            issued_q       <= issued_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            m_rst_q        <= m_rst_d;
            tx_done_seen_q <= tx_done_seen_d;
        end
    end

endmodule
